trace_frontend: RTL and testbench

Parametrised trace-input front end between the board pins and the trace capture core. It registers the raw trace and user-header pins and remaps them per board revision. It masks lanes outside the selected trace port width and muxes out the SWO line. It also provides per-lane toggle-activity monitoring and a capture-aware heartbeat counter for the clock-alive LED.

---
 rtl/trace_frontend_if.sv | 35 +++
 rtl/trace_frontend.sv | 138 +++++++++++++
 tb/tb_trace_frontend.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_frontend_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : trace_frontend_if
// Desc   : Pin-side inputs and capture-side outputs of the trace front end.
// Rev    : 1.0 - initial release
//==============================================================================
interface trace_frontend_if #(
  parameter int pTRACE_WIDTH  = 4,
  parameter int pUSERIO_WIDTH = 4,
  parameter int pACT_CNT_BITS = 16
);
  logic [pTRACE_WIDTH-1:0]               I_trace_pins;
  logic [pUSERIO_WIDTH-1:0]              I_userio;
  logic [3:0]                            I_board_rev;
  logic [1:0]                            I_port_width;
  logic                                  I_capturing;
  logic                                  I_act_clear;
  logic [pTRACE_WIDTH-1:0]               O_trace_data;
  logic                                  O_swo;
  logic                                  O_heartbeat;
  logic [pTRACE_WIDTH-1:0]               O_lane_active;
  logic [pTRACE_WIDTH*pACT_CNT_BITS-1:0] O_act_count;

  modport slave (
    input  I_trace_pins, I_userio, I_board_rev, I_port_width, I_capturing, I_act_clear,
    output O_trace_data, O_swo, O_heartbeat, O_lane_active, O_act_count
  );

  modport master (
    output I_trace_pins, I_userio, I_board_rev, I_port_width, I_capturing, I_act_clear,
    input  O_trace_data, O_swo, O_heartbeat, O_lane_active, O_act_count
  );
endinterface
`default_nettype wire

// File: rtl/trace_frontend.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : trace_frontend
// Desc   : Registers, remaps and masks trace pins; lane activity and heartbeat.
// Rev    : 1.0 - initial release
//==============================================================================
module trace_frontend #(
  parameter int pTRACE_WIDTH     = 4,
  parameter int pUSERIO_WIDTH    = 4,
  parameter int pHEARTBEAT_BITS  = 23,
  parameter int pACT_CNT_BITS    = 16,
  parameter int pACT_WINDOW_BITS = 10
) (
  input  logic            trace_clk,
  input  logic            reset_n,
  trace_frontend_if.slave bus
);

  localparam logic [3:0] c_rev_remap = 4'd3;

  logic [pTRACE_WIDTH-1:0]     r_raw_t;
  logic [pUSERIO_WIDTH-1:0]    r_raw_u;
  logic [pTRACE_WIDTH-1:0]     w_mapped;
  logic [pTRACE_WIDTH-1:0]     w_enable;
  logic [pTRACE_WIDTH-1:0]     w_toggle;
  logic [pTRACE_WIDTH-1:0]     r_prev;
  logic [pTRACE_WIDTH-1:0]     r_seen;
  logic [pTRACE_WIDTH-1:0]     r_active;
  logic                        w_swo;
  logic [31:0]                 w_lanes;
  logic [pACT_WINDOW_BITS-1:0] r_win;
  logic                        w_wrap;
  logic [pHEARTBEAT_BITS-1:0]  r_hb;
  logic [pACT_CNT_BITS-1:0]    r_cnt [pTRACE_WIDTH];
  logic                        w_unused_u;

  // Only a few header bits are routed; the rest are registered but unused.
  assign w_unused_u = ^r_raw_u;

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_t <= '0;
      r_raw_u <= '0;
    end else begin
      r_raw_t <= bus.I_trace_pins;
      r_raw_u <= bus.I_userio;
    end
  end

  always_comb begin
    w_mapped = r_raw_t;
    w_swo    = r_raw_u[2];
    if (bus.I_board_rev == c_rev_remap) begin
      w_mapped[0] = r_raw_u[3];
      w_mapped[1] = r_raw_t[2];
      w_mapped[2] = r_raw_t[1];
      w_swo       = r_raw_u[1];
    end
  end

  always_comb begin
    w_enable = '0;
    case (bus.I_port_width)
      2'd0:    w_lanes = 32'd1;
      2'd1:    w_lanes = 32'd2;
      2'd2:    w_lanes = 32'd4;
      default: w_lanes = 32'(pTRACE_WIDTH);
    endcase
    for (int i = 0; i < pTRACE_WIDTH; i++) begin
      w_enable[i] = (32'(i) < w_lanes);
    end
  end

  // Activity looks at the unmasked mapped value so re-enabling a lane never fakes a toggle.
  assign w_toggle = (w_mapped ^ r_prev) & w_enable;
  assign w_wrap   = &r_win;

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.O_trace_data <= '0;
      bus.O_swo        <= 1'b0;
      r_prev           <= '0;
    end else begin
      bus.O_trace_data <= w_mapped & w_enable;
      bus.O_swo        <= w_swo;
      r_prev           <= w_mapped;
    end
  end

  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win    <= '0;
      r_seen   <= '0;
      r_active <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (w_wrap) begin
        r_active <= r_seen | w_toggle;
        r_seen   <= '0;
      end else begin
        r_seen   <= r_seen | w_toggle;
      end
    end
  end

  assign bus.O_lane_active = r_active;

  // Heartbeat freezes during capture to keep LED switching noise off the trace pins.
  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hb            <= '0;
      bus.O_heartbeat <= 1'b0;
    end else begin
      if (!bus.I_capturing) begin
        r_hb <= r_hb + 1'b1;
      end
      bus.O_heartbeat <= r_hb[pHEARTBEAT_BITS-1];
    end
  end

  generate
    for (genvar i = 0; i < pTRACE_WIDTH; i++) begin : g_lane
      always_ff @(posedge trace_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt[i] <= '0;
        end else if (bus.I_act_clear) begin
          r_cnt[i] <= '0;
        end else if (w_toggle[i] && !(&r_cnt[i])) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      assign bus.O_act_count[i*pACT_CNT_BITS +: pACT_CNT_BITS] = r_cnt[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_trace_frontend.sv
`timescale 1ns/1ps
// Bench for trace_frontend: table vectors with a latency scoreboard plus
// hand-written activity, heartbeat and reset sequences.
module tb_trace_frontend;
  localparam int TW = 4;
  localparam int UW = 4;
  localparam int HB = 4;
  localparam int CB = 16;
  localparam int WB = 4;

  logic trace_clk = 1'b0;
  logic reset_n   = 1'b0;

  trace_frontend_if #(.pTRACE_WIDTH(TW), .pUSERIO_WIDTH(UW), .pACT_CNT_BITS(CB)) bus ();

  trace_frontend #(
    .pTRACE_WIDTH(TW), .pUSERIO_WIDTH(UW), .pHEARTBEAT_BITS(HB),
    .pACT_CNT_BITS(CB), .pACT_WINDOW_BITS(WB)
  ) dut (
    .trace_clk (trace_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 trace_clk = ~trace_clk;

  typedef struct {
    logic [3:0] pins;
    logic [3:0] uio;
    logic [3:0] rev;
    logic [1:0] w;
    logic [3:0] exp_d;
    logic       exp_s;
  } vec_t;

  vec_t       vecs [9];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [3:0] m_raw_t, m_raw_u;
  logic [HB-1:0] m_hb;
  logic       m_led;
  logic [4:0] sb_q [$];
  bit         sb_on = 1'b0;
  bit         hb_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {swo, data} from the stage-1 contents and the current rev/width.
  function automatic logic [4:0] exp_map(input logic [3:0] t, input logic [3:0] u,
                                         input logic [3:0] rev, input logic [1:0] w);
    logic [3:0] d;
    logic       s;
    if (rev == 4'd3) begin
      d = {t[3], t[1], t[2], u[3]};
      s = u[1];
    end else begin
      d = t;
      s = u[2];
    end
    case (w)
      2'd0:    d = d & 4'b0001;
      2'd1:    d = d & 4'b0011;
      default: d = d;
    endcase
    return {s, d};
  endfunction

  function automatic logic [CB-1:0] cnt(input int i);
    return bus.O_act_count[i*CB +: CB];
  endfunction

  task automatic reset_model();
    m_raw_t = '0;
    m_raw_u = '0;
    m_hb    = '0;
    m_led   = 1'b0;
    sb_q.delete();
    cyc     = 0;
  endtask

  task automatic step();
    logic [4:0] e;
    sb_q.push_back(exp_map(m_raw_t, m_raw_u, bus.I_board_rev, bus.I_port_width));
    m_raw_t = bus.I_trace_pins;
    m_raw_u = bus.I_userio;
    m_led   = m_hb[HB-1];
    if (!bus.I_capturing) m_hb = m_hb + 1'b1;
    @(posedge trace_clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    if (sb_on) begin
      chk("trace_data", 64'(bus.O_trace_data), 64'(e[3:0]));
      chk("swo", 64'(bus.O_swo), 64'(e[4]));
    end
    if (hb_on) chk("heartbeat", 64'(bus.O_heartbeat), 64'(m_led));
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 16 && (cyc % 16) != ph; k++) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},   64'(bus.O_trace_data),  64'd0);
    chk({tag, "_swo"},    64'(bus.O_swo),         64'd0);
    chk({tag, "_hb"},     64'(bus.O_heartbeat),   64'd0);
    chk({tag, "_active"}, 64'(bus.O_lane_active), 64'd0);
    chk({tag, "_counts"}, bus.O_act_count,        64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int highs;
    vecs[0] = '{4'b1011, 4'b0100, 4'd4,  2'd1, 4'b0011, 1'b1};
    vecs[1] = '{4'b1011, 4'b0000, 4'd4,  2'd2, 4'b1011, 1'b0};
    vecs[2] = '{4'b0100, 4'b1000, 4'd3,  2'd3, 4'b0011, 1'b0};
    vecs[3] = '{4'b0100, 4'b0010, 4'd3,  2'd3, 4'b0010, 1'b1};
    vecs[4] = '{4'b0100, 4'b1010, 4'd4,  2'd3, 4'b0100, 1'b0};
    vecs[5] = '{4'b1111, 4'b1111, 4'd4,  2'd0, 4'b0001, 1'b1};
    vecs[6] = '{4'b1010, 4'b0000, 4'd3,  2'd3, 4'b1100, 1'b0};
    vecs[7] = '{4'b0110, 4'b0000, 4'd3,  2'd1, 4'b0010, 1'b0};
    vecs[8] = '{4'b1111, 4'b0100, 4'd15, 2'd2, 4'b1111, 1'b1};

    bus.I_trace_pins = '0;
    bus.I_userio     = '0;
    bus.I_board_rev  = 4'd4;
    bus.I_port_width = 2'd1;
    bus.I_capturing  = 1'b0;
    bus.I_act_clear  = 1'b0;
    repeat (3) @(posedge trace_clk);
    #1;
    check_all_zero("reset");

    // Release away from the edge; pins sampled from the first edge onward.
    #4;
    reset_n = 1'b1;
    reset_model();
    sb_on = 1'b1;
    hb_on = 1'b1;
    bus.I_trace_pins = 4'b1011;
    bus.I_userio     = 4'b0100;
    step();
    chk("latency_c1_data", 64'(bus.O_trace_data), 64'd0);
    step();
    chk("latency_c2_data", 64'(bus.O_trace_data), 64'b0011);
    chk("latency_c2_swo",  64'(bus.O_swo), 64'd1);
    bus.I_userio = 4'b0000;
    step();
    chk("swo_lat_c1", 64'(bus.O_swo), 64'd1);
    step();
    chk("swo_lat_c2", 64'(bus.O_swo), 64'd0);

    foreach (vecs[i]) begin
      bus.I_trace_pins = vecs[i].pins;
      bus.I_userio     = vecs[i].uio;
      bus.I_board_rev  = vecs[i].rev;
      bus.I_port_width = vecs[i].w;
      step();
      step();
      chk($sformatf("vec%0d_data", i), 64'(bus.O_trace_data), 64'(vecs[i].exp_d));
      chk($sformatf("vec%0d_swo", i),  64'(bus.O_swo), 64'(vecs[i].exp_s));
    end

    // Revision change with pins held: visible one cycle later.
    bus.I_trace_pins = 4'b0100;
    bus.I_userio     = 4'b1000;
    bus.I_board_rev  = 4'd3;
    bus.I_port_width = 2'd3;
    step();
    step();
    chk("rev3_data", 64'(bus.O_trace_data), 64'b0011);
    bus.I_board_rev = 4'd4;
    step();
    chk("rev_switch_data", 64'(bus.O_trace_data), 64'b0100);

    // Heartbeat duty cycle and freeze during capture.
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.O_heartbeat) highs++;
    end
    chk("hb_duty", 64'(highs), 64'd8);
    bus.I_capturing = 1'b1;
    repeat (20) step();
    bus.I_capturing = 1'b0;
    repeat (20) step();

    // Single toggle on lane 1 inside a window.
    bus.I_trace_pins = 4'b0000;
    bus.I_userio     = 4'b0000;
    repeat (40) step();
    chk("quiet_active", 64'(bus.O_lane_active), 64'd0);
    wait_phase(2);
    bus.I_trace_pins = 4'b0010;
    wait_phase(0);
    chk("win_lane1_set", 64'(bus.O_lane_active), 64'b0010);
    step();
    wait_phase(0);
    chk("win_lane1_clr", 64'(bus.O_lane_active), 64'b0000);

    // Toggle landing exactly on the wrap cycle still marks the lane.
    wait_phase(14);
    bus.I_trace_pins = 4'b0110;
    wait_phase(0);
    chk("win_wrap_toggle", 64'(bus.O_lane_active), 64'b0100);
    step();
    wait_phase(0);
    chk("win_wrap_clr", 64'(bus.O_lane_active), 64'b0000);

    // Masked lane 3 toggling: no counts, no activity.
    bus.I_port_width = 2'd0;
    repeat (3) step();
    bus.I_act_clear = 1'b1;
    step();
    bus.I_act_clear = 1'b0;
    chk("clear_counts", bus.O_act_count, 64'd0);
    for (int k = 0; k < 40; k++) begin
      bus.I_trace_pins = bus.I_trace_pins ^ 4'b1000;
      step();
    end
    chk("masked_cnt3",   64'(cnt(3)), 64'd0);
    chk("masked_active", 64'(bus.O_lane_active), 64'd0);

    // Exact toggle count on lane 1.
    bus.I_port_width = 2'd3;
    repeat (3) step();
    bus.I_act_clear = 1'b1;
    step();
    bus.I_act_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.I_trace_pins = bus.I_trace_pins ^ 4'b0010;
      step();
    end
    repeat (3) step();
    chk("count5_lane1", 64'(cnt(1)), 64'd5);
    chk("count5_lane2", 64'(cnt(2)), 64'd0);
    chk("count5_lane3", 64'(cnt(3)), 64'd0);

    // Saturation, then clear winning over a simultaneous toggle.
    for (int k = 0; k < 70000; k++) begin
      bus.I_trace_pins = bus.I_trace_pins ^ 4'b0001;
      step();
    end
    chk("sat_lane0", 64'(cnt(0)), 64'd65535);
    bus.I_act_clear  = 1'b1;
    bus.I_trace_pins = bus.I_trace_pins ^ 4'b0001;
    step();
    chk("clear_on_toggle", 64'(cnt(0)), 64'd0);
    bus.I_act_clear  = 1'b0;
    bus.I_trace_pins = bus.I_trace_pins ^ 4'b0001;
    step();
    chk("count_after_clear", 64'(cnt(0)), 64'd1);

    // Asynchronous reset between edges.
    bus.I_trace_pins = 4'b1111;
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge trace_clk);
    #1;
    check_all_zero("async_hold");
    #4;
    reset_n = 1'b1;
    reset_model();
    repeat (4) step();
    chk("post_rst_data", 64'(bus.O_trace_data), 64'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
